// File: rtl/digit_entry_ctrl.sv
// Operand digit-entry controller: turns debounced button levels into accumulator load/clear strobes.
// Optional inactivity timeout is compiled in with `define ENTRY_TIMEOUT_EN.
module digit_entry_ctrl #(
  parameter int unsigned N              = 16,
  parameter int unsigned MAX_DIGITS     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 100000000
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               btn_digit,
  input  logic                               btn_enter,
  input  logic                               btn_clear,
  input  logic                               mode_sel,
  input  logic [3:0]                         sin,
  output logic                               acc_load,
  output logic                               acc_clr,
  output logic                               acc_mode,
  output logic [3:0]                         acc_din,
  output logic                               op_valid,
  output logic                               op_sel,
  output logic                               err,
  output logic [$clog2(MAX_DIGITS+1)-1:0]    digit_cnt,
  output logic                               done
);

  localparam int unsigned CW = $clog2(MAX_DIGITS + 1);

  typedef enum logic [1:0] {S_A, S_B, S_DONE} state_t;

  // A full operand of hex digits must fit the downstream accumulator.
  if (4 * MAX_DIGITS > N) begin : g_width_chk
    $error("digit_entry_ctrl: MAX_DIGITS hex digits exceed accumulator width N");
  end

  state_t          state_q, state_d;
  logic            dig_prev_q, ent_prev_q, clr_prev_q;
  logic            acc_load_q, acc_load_d;
  logic            acc_clr_q, acc_clr_d;
  logic            acc_mode_q, acc_mode_d;
  logic [3:0]      acc_din_q, acc_din_d;
  logic            op_valid_q, op_valid_d;
  logic            op_sel_q, op_sel_d;
  logic            err_q, err_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            done_q, done_d;
  logic            pend_q, pend_d;

  logic            dig_ev, ent_ev, clr_ev;
  logic            mode_eff;
  logic            tmo_hit;

  assign dig_ev = btn_digit & ~dig_prev_q;
  assign ent_ev = btn_enter & ~ent_prev_q;
  assign clr_ev = btn_clear & ~clr_prev_q;

  // Radix that the incoming digit will be judged against.
  assign mode_eff = (cnt_q == '0) ? mode_sel : acc_mode_q;

`ifdef ENTRY_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmr_q, tmr_d;
  logic          tmr_run;

  assign tmr_run = ~(dig_ev | ent_ev | clr_ev) & ~pend_q &
                   (state_q != S_DONE) & (cnt_q != '0);
  assign tmo_hit = tmr_run && (tmr_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tmr_d = '0;
    if (tmr_run && !tmo_hit) begin
      tmr_d = tmr_q + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tmr_q <= '0;
    end else begin
      tmr_q <= tmr_d;
    end
  end
`else
  if (TIMEOUT_CYCLES == 0) begin : g_tmo_chk
    $error("digit_entry_ctrl: TIMEOUT_CYCLES must be nonzero");
  end

  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    acc_load_d = 1'b0;
    acc_clr_d  = 1'b0;
    acc_mode_d = acc_mode_q;
    acc_din_d  = acc_din_q;
    op_valid_d = 1'b0;
    op_sel_d   = op_sel_q;
    err_d      = 1'b0;
    cnt_d      = cnt_q;
    pend_d     = 1'b0;

    if (clr_ev) begin
      state_d   = S_A;
      acc_clr_d = 1'b1;
      op_sel_d  = 1'b0;
      cnt_d     = '0;
    end else if (pend_q) begin
      // Second half of committing A: enter/digit events on this cycle are dropped.
      acc_clr_d = 1'b1;
      op_sel_d  = 1'b1;
      cnt_d     = '0;
    end else if (state_q != S_DONE) begin
      if (ent_ev) begin
        if (cnt_q == '0) begin
          err_d = 1'b1;
        end else begin
          op_valid_d = 1'b1;
          if (state_q == S_A) begin
            state_d = S_B;
            pend_d  = 1'b1;
          end else begin
            state_d = S_DONE;
          end
        end
      end else if (dig_ev) begin
        if (cnt_q == CW'(MAX_DIGITS) || (mode_eff && sin > 4'd9)) begin
          err_d = 1'b1;
        end else begin
          acc_load_d = 1'b1;
          acc_din_d  = sin;
          acc_mode_d = mode_eff;
          cnt_d      = cnt_q + CW'(1);
        end
      end else if (tmo_hit) begin
        err_d     = 1'b1;
        acc_clr_d = 1'b1;
        cnt_d     = '0;
      end
    end

    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_A;
      dig_prev_q <= 1'b1;
      ent_prev_q <= 1'b1;
      clr_prev_q <= 1'b1;
      acc_load_q <= 1'b0;
      acc_clr_q  <= 1'b1;
      acc_mode_q <= 1'b0;
      acc_din_q  <= '0;
      op_valid_q <= 1'b0;
      op_sel_q   <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      pend_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      dig_prev_q <= btn_digit;
      ent_prev_q <= btn_enter;
      clr_prev_q <= btn_clear;
      acc_load_q <= acc_load_d;
      acc_clr_q  <= acc_clr_d;
      acc_mode_q <= acc_mode_d;
      acc_din_q  <= acc_din_d;
      op_valid_q <= op_valid_d;
      op_sel_q   <= op_sel_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      pend_q     <= pend_d;
    end
  end

  assign acc_load  = acc_load_q;
  assign acc_clr   = acc_clr_q;
  assign acc_mode  = acc_mode_q;
  assign acc_din   = acc_din_q;
  assign op_valid  = op_valid_q;
  assign op_sel    = op_sel_q;
  assign err       = err_q;
  assign digit_cnt = cnt_q;
  assign done      = done_q;

endmodule

// File: tb/tb_digit_entry_ctrl.sv
// Directed bench for digit_entry_ctrl: hex/decimal entry, digit limit, clear priority, reset behaviour.
// With ENTRY_TIMEOUT_EN defined, also covers the inactivity timeout (TIMEOUT_CYCLES = 10).
module tb_digit_entry_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_digit, btn_enter, btn_clear, mode_sel;
  logic [3:0] sin;
  logic       acc_load, acc_clr, acc_mode, op_valid, op_sel, err, done;
  logic [3:0] acc_din;
  logic [2:0] digit_cnt;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  digit_entry_ctrl #(
    .N              (16),
    .MAX_DIGITS     (4),
    .TIMEOUT_CYCLES (10)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_digit (btn_digit),
    .btn_enter (btn_enter),
    .btn_clear (btn_clear),
    .mode_sel  (mode_sel),
    .sin       (sin),
    .acc_load  (acc_load),
    .acc_clr   (acc_clr),
    .acc_mode  (acc_mode),
    .acc_din   (acc_din),
    .op_valid  (op_valid),
    .op_sel    (op_sel),
    .err       (err),
    .digit_cnt (digit_cnt),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Outputs of the edge just taken are stable 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic digit(input logic [3:0] v);
    sin       = v;
    btn_digit = 1'b1;
    tick();
  endtask

  task automatic release_all();
    btn_digit = 1'b0;
    btn_enter = 1'b0;
    btn_clear = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b0; btn_digit = 1'b0; btn_enter = 1'b0; btn_clear = 1'b0;
    mode_sel = 1'b0; sin = 4'h0;
    tick(); tick();
    chk("rst_acc_clr",  acc_clr,   1);
    chk("rst_acc_load", acc_load,  0);
    chk("rst_op_valid", op_valid,  0);
    chk("rst_err",      err,       0);
    chk("rst_done",     done,      0);
    chk("rst_op_sel",   op_sel,    0);
    chk("rst_mode",     acc_mode,  0);
    chk("rst_din",      acc_din,   0);
    chk("rst_cnt",      digit_cnt, 0);
    rst = 1'b1;
    tick();
    chk("post_rst_clr", acc_clr, 0);

    // Hex operand A = A3
    mode_sel = 1'b0;
    digit(4'hA);
    chk("hexA_load", acc_load, 1); chk("hexA_din", acc_din, 4'hA);
    chk("hexA_cnt", digit_cnt, 1); chk("hexA_mode", acc_mode, 0);
    release_all();
    chk("hexA_load_off", acc_load, 0);
    digit(4'h3);
    chk("hex3_load", acc_load, 1); chk("hex3_din", acc_din, 4'h3); chk("hex3_cnt", digit_cnt, 2);
    release_all();
    btn_enter = 1'b1; tick();
    chk("entA_valid", op_valid, 1); chk("entA_sel", op_sel, 0); chk("entA_clr", acc_clr, 0);
    release_all();
    chk("entA2_clr", acc_clr, 1); chk("entA2_sel", op_sel, 1);
    chk("entA2_cnt", digit_cnt, 0); chk("entA2_valid", op_valid, 0);
    tick();
    chk("entA3_clr", acc_clr, 0);

    // Decimal operand B: illegal first digit, then mode locked after first accepted digit
    mode_sel = 1'b1;
    digit(4'hC);
    chk("decC_err", err, 1); chk("decC_load", acc_load, 0); chk("decC_cnt", digit_cnt, 0);
    release_all();
    chk("decC_err_off", err, 0);
    digit(4'h7);
    chk("dec7_load", acc_load, 1); chk("dec7_din", acc_din, 7);
    chk("dec7_mode", acc_mode, 1); chk("dec7_cnt", digit_cnt, 1);
    release_all();
    mode_sel = 1'b0;
    digit(4'hB);
    chk("decB_err", err, 1); chk("decB_load", acc_load, 0);
    chk("decB_mode", acc_mode, 1); chk("decB_cnt", digit_cnt, 1);
    release_all();

    // Fill to MAX_DIGITS, fifth accepted attempt rejected
    digit(4'h5); chk("d5_load", acc_load, 1); release_all();
    digit(4'h1); chk("d1_load", acc_load, 1); release_all();
    digit(4'h2); chk("d2_load", acc_load, 1); chk("d2_cnt", digit_cnt, 4); release_all();
    digit(4'h4);
    chk("over_err", err, 1); chk("over_load", acc_load, 0); chk("over_cnt", digit_cnt, 4);
    release_all();
    btn_enter = 1'b1; tick();
    chk("entB_valid", op_valid, 1); chk("entB_sel", op_sel, 1);
    chk("entB_done", done, 1); chk("entB_clr", acc_clr, 0);
    release_all();
    chk("entB_valid_off", op_valid, 0);

    // S_DONE ignores digit and enter silently
    digit(4'h1);
    chk("done_dig_load", acc_load, 0); chk("done_dig_err", err, 0); chk("done_dig_cnt", digit_cnt, 4);
    release_all();
    btn_enter = 1'b1; tick();
    chk("done_ent_valid", op_valid, 0); chk("done_ent_err", err, 0);
    release_all();
    btn_clear = 1'b1; tick();
    chk("done_clr_clr", acc_clr, 1); chk("done_clr_sel", op_sel, 0);
    chk("done_clr_cnt", digit_cnt, 0); chk("done_clr_done", done, 0);
    release_all();

    // Enter with no digits in S_A
    btn_enter = 1'b1; tick();
    chk("empty_ent_err", err, 1); chk("empty_ent_valid", op_valid, 0);
    release_all();

    // Move into operand B with one digit, then clear+enter+digit together
    digit(4'h1); release_all();
    btn_enter = 1'b1; tick(); release_all(); tick();
    chk("toB_sel", op_sel, 1);
    digit(4'h2); chk("B_load", acc_load, 1); chk("B_cnt", digit_cnt, 1);
    release_all();
    sin = 4'h6; btn_clear = 1'b1; btn_enter = 1'b1; btn_digit = 1'b1; tick();
    chk("prio_clr", acc_clr, 1); chk("prio_valid", op_valid, 0); chk("prio_load", acc_load, 0);
    chk("prio_sel", op_sel, 0); chk("prio_cnt", digit_cnt, 0); chk("prio_err", err, 0);
    release_all();
    btn_enter = 1'b1; tick();
    chk("prio_inA_err", err, 1);
    release_all();

    // Reset mid-operand abandons it
    digit(4'h9); release_all();
    rst = 1'b0; tick();
    chk("midrst_valid", op_valid, 0); chk("midrst_cnt", digit_cnt, 0); chk("midrst_clr", acc_clr, 1);

    // Digit button held through reset release
    btn_digit = 1'b1; tick();
    rst = 1'b1; tick();
    chk("held_load", acc_load, 0); chk("held_clr", acc_clr, 0); chk("held_cnt", digit_cnt, 0);
    tick();
    chk("held_load2", acc_load, 0);
    release_all();

`ifdef ENTRY_TIMEOUT_EN
    digit(4'h4); chk("tmo_load", acc_load, 1);
    btn_digit = 1'b0;
    for (int i = 1; i < 10; i++) begin
      tick();
      chk("tmo_quiet", err, 0);
    end
    tick();
    chk("tmo_err", err, 1); chk("tmo_clr", acc_clr, 1); chk("tmo_cnt", digit_cnt, 0);
    chk("tmo_sel", op_sel, 0);
    tick();
    chk("tmo_err_off", err, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
